// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives instruction-memory requests, buffers the returned word for
// decode, and issues one PC step per consumed or squashed fetch, honouring execute redirects.
module fetch_sequencer #(
    parameter int W_CPU    = 32,
    parameter int W_PC_SRC = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    input  logic                imem_ack,
    input  logic [W_CPU-1:0]    imem_rdata,
    output logic                inst_valid,
    output logic [W_CPU-1:0]    inst,
    input  logic                inst_ready,
    input  logic                redir_valid,
    input  logic [W_PC_SRC-1:0] redir_src,
    input  logic                redir_taken,
    output logic                pc_step,
    output logic [W_PC_SRC-1:0] pc_src,
    output logic                branch_ctrl,
    output logic                timeout
);

    localparam logic [W_PC_SRC-1:0] PC_SRC_NEXT = W_PC_SRC'(0);
    localparam logic [W_PC_SRC-1:0] PC_SRC_BRCH = W_PC_SRC'(2);
    localparam int                  CNT_W       = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]    WAIT_MAX    = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, STEP} state_t;

    state_t                state_q;
    logic                  imem_req_q;
    logic                  inst_valid_q;
    logic [W_CPU-1:0]      inst_q;
    logic                  pc_step_q;
    logic [W_PC_SRC-1:0]   pc_src_q;
    logic                  branch_ctrl_q;
    logic                  timeout_q;
    logic [CNT_W-1:0]      wait_q;
    logic [CNT_W-1:0]      wait_d;
    logic                  squash_q;
    logic [W_PC_SRC-1:0]   pend_src_q;
    logic                  pend_taken_q;
    logic [W_PC_SRC-1:0]   sel_src_d;
    logic                  sel_taken_d;

    function automatic logic brch_ctrl(input logic [W_PC_SRC-1:0] src, input logic taken);
        return (src == PC_SRC_BRCH) && taken;
    endfunction

    // A redirect arriving in the same cycle as the squashed ack is newer than the pending one.
    always_comb begin
        sel_src_d   = redir_valid ? redir_src   : pend_src_q;
        sel_taken_d = redir_valid ? redir_taken : pend_taken_q;
        wait_d      = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            imem_req_q    <= 1'b0;
            inst_valid_q  <= 1'b0;
            inst_q        <= '0;
            pc_step_q     <= 1'b0;
            pc_src_q      <= PC_SRC_NEXT;
            branch_ctrl_q <= 1'b0;
            timeout_q     <= 1'b0;
            wait_q        <= '0;
            squash_q      <= 1'b0;
            pend_src_q    <= PC_SRC_NEXT;
            pend_taken_q  <= 1'b0;
        end else begin
            pc_step_q     <= 1'b0;
            pc_src_q      <= PC_SRC_NEXT;
            branch_ctrl_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (redir_valid) begin
                        squash_q     <= 1'b1;
                        pend_src_q   <= redir_src;
                        pend_taken_q <= redir_taken;
                    end
                    imem_req_q <= 1'b1;
                    state_q    <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        wait_q     <= '0;
                        imem_req_q <= 1'b0;
                        if (squash_q || redir_valid) begin
                            pc_step_q     <= 1'b1;
                            pc_src_q      <= sel_src_d;
                            branch_ctrl_q <= brch_ctrl(sel_src_d, sel_taken_d);
                            squash_q      <= 1'b0;
                            pend_src_q    <= PC_SRC_NEXT;
                            pend_taken_q  <= 1'b0;
                            state_q       <= STEP;
                        end else begin
                            inst_q       <= imem_rdata;
                            inst_valid_q <= 1'b1;
                            state_q      <= HOLD;
                        end
                    end else begin
                        wait_q <= wait_d;
                        if (wait_d == WAIT_MAX) begin
                            timeout_q <= 1'b1;
                        end
                        if (redir_valid) begin
                            squash_q     <= 1'b1;
                            pend_src_q   <= redir_src;
                            pend_taken_q <= redir_taken;
                        end
                    end
                end
                HOLD: begin
                    if (redir_valid) begin
                        inst_valid_q  <= 1'b0;
                        pc_step_q     <= 1'b1;
                        pc_src_q      <= redir_src;
                        branch_ctrl_q <= brch_ctrl(redir_src, redir_taken);
                        squash_q      <= 1'b0;
                        pend_src_q    <= PC_SRC_NEXT;
                        pend_taken_q  <= 1'b0;
                        state_q       <= STEP;
                    end else if (inst_ready) begin
                        inst_valid_q <= 1'b0;
                        pc_step_q    <= 1'b1;
                        state_q      <= STEP;
                    end
                end
                STEP: begin
                    // The step on the outputs is already committed; a redirect here squashes the next fetch.
                    if (redir_valid) begin
                        squash_q     <= 1'b1;
                        pend_src_q   <= redir_src;
                        pend_taken_q <= redir_taken;
                    end
                    imem_req_q <= 1'b1;
                    state_q    <= FETCH;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign inst_valid  = inst_valid_q;
    assign inst        = inst_q;
    assign pc_step     = pc_step_q;
    assign pc_src      = pc_src_q;
    assign branch_ctrl = branch_ctrl_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expected pc_step and instruction events go into
// queues; a monitor pops and compares them whenever the DUT presents one.
module tb_fetch_sequencer;

    localparam int W_CPU    = 32;
    localparam int W_PC_SRC = 2;
    localparam int MAX_WAIT = 15;
    localparam logic [1:0] NEXT = 2'd0, JUMP = 2'd1, BRCH = 2'd2, REGS = 2'd3;

    logic                clk = 1'b0;
    logic                rst;
    logic                imem_req;
    logic                imem_ack;
    logic [W_CPU-1:0]    imem_rdata;
    logic                inst_valid;
    logic [W_CPU-1:0]    inst;
    logic                inst_ready;
    logic                redir_valid;
    logic [W_PC_SRC-1:0] redir_src;
    logic                redir_taken;
    logic                pc_step;
    logic [W_PC_SRC-1:0] pc_src;
    logic                branch_ctrl;
    logic                timeout;

    int n_chk  = 0;
    int n_pass = 0;

    logic [2:0]  step_exp_q[$];
    logic [31:0] inst_exp_q[$];
    logic [2:0]  step_e;
    logic [31:0] inst_e;
    logic        prev_valid = 1'b0;

    fetch_sequencer #(.W_CPU(W_CPU), .W_PC_SRC(W_PC_SRC), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
        .redir_valid(redir_valid), .redir_src(redir_src), .redir_taken(redir_taken),
        .pc_step(pc_step), .pc_src(pc_src), .branch_ctrl(branch_ctrl), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every pc_step pulse and every rising inst_valid must match the next queued expectation.
    always @(negedge clk) begin
        if (pc_step === 1'b1) begin
            if (step_exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_pc_step: got src=%0d bc=%0b, expected none", pc_src, branch_ctrl);
            end else begin
                step_e = step_exp_q.pop_front();
                check("step_pc_src", {30'b0, pc_src}, {30'b0, step_e[2:1]});
                check("step_branch_ctrl", {31'b0, branch_ctrl}, {31'b0, step_e[0]});
            end
        end
        if (inst_valid === 1'b1 && prev_valid == 1'b0) begin
            if (inst_exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_inst_valid: got inst=0x%0h, expected none", inst);
            end else begin
                inst_e = inst_exp_q.pop_front();
                check("inst_value", inst, inst_e);
            end
        end
        prev_valid <= inst_valid;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push_step(input logic [1:0] src, input logic bc);
        step_exp_q.push_back({src, bc});
    endtask

    task automatic fetch_ack(input int n, input logic [31:0] d, input bit expect_inst);
        repeat (n) cyc();
        imem_ack   = 1'b1;
        imem_rdata = d;
        if (expect_inst) inst_exp_q.push_back(d);
        cyc();
        imem_ack = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_imem_req"},    {31'b0, imem_req},    32'd0);
        check({tag, "_inst_valid"},  {31'b0, inst_valid},  32'd0);
        check({tag, "_inst"},        inst,                 32'd0);
        check({tag, "_pc_step"},     {31'b0, pc_step},     32'd0);
        check({tag, "_pc_src"},      {30'b0, pc_src},      {30'b0, NEXT});
        check({tag, "_branch_ctrl"}, {31'b0, branch_ctrl}, 32'd0);
        check({tag, "_timeout"},     {31'b0, timeout},     32'd0);
    endtask

    task automatic consume();
        inst_ready = 1'b1;
        push_step(NEXT, 1'b0);
        cyc();
        inst_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0BAD;
        inst_ready = 1'b0; redir_valid = 1'b0; redir_src = NEXT; redir_taken = 1'b0;
        repeat (2) cyc();
        check_reset_vals("reset");
        imem_ack = 1'b0;
        rst = 1'b0;
        cyc();
        check("req_after_reset", {31'b0, imem_req}, 32'd1);

        // Basic fetch, 1-cycle ack-to-valid, consume.
        fetch_ack(0, 32'h2002_0005, 1'b1);
        check("basic_valid", {31'b0, inst_valid}, 32'd1);
        check("req_drop_after_ack", {31'b0, imem_req}, 32'd0);
        consume();
        check("valid_clear_on_step", {31'b0, inst_valid}, 32'd0);
        cyc();
        check("refetch_req", {31'b0, imem_req}, 32'd1);
        check("no_back_to_back_step", {31'b0, pc_step}, 32'd0);

        // Decode stall.
        fetch_ack(2, 32'h1111_2222, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("stall_valid", {31'b0, inst_valid}, 32'd1);
            check("stall_inst", inst, 32'h1111_2222);
            check("stall_no_step", {31'b0, pc_step}, 32'd0);
            cyc();
        end
        consume();
        cyc();

        // Branch during outstanding fetch squashes the returned word.
        redir_valid = 1'b1; redir_src = BRCH; redir_taken = 1'b1;
        cyc();
        redir_valid = 1'b0; redir_taken = 1'b0;
        push_step(BRCH, 1'b1);
        fetch_ack(2, 32'hDEAD_BEEF, 1'b0);
        check("squash_no_valid", {31'b0, inst_valid}, 32'd0);
        cyc();

        // Redirect beats decode handshake in HOLD.
        fetch_ack(0, 32'h3333_4444, 1'b1);
        inst_ready = 1'b1; redir_valid = 1'b1; redir_src = JUMP; redir_taken = 1'b1;
        push_step(JUMP, 1'b0);
        cyc();
        inst_ready = 1'b0; redir_valid = 1'b0; redir_taken = 1'b0;
        check("hold_redir_drop", {31'b0, inst_valid}, 32'd0);
        cyc();

        // Two redirects before ack: last one wins.
        redir_valid = 1'b1; redir_src = BRCH; redir_taken = 1'b1;
        cyc();
        redir_src = REGS; redir_taken = 1'b1;
        cyc();
        redir_valid = 1'b0; redir_taken = 1'b0;
        push_step(REGS, 1'b0);
        fetch_ack(1, 32'h5555_6666, 1'b0);
        cyc();

        // Redirect during STEP: current step unchanged, next fetch squashed.
        fetch_ack(0, 32'h7777_8888, 1'b1);
        consume();
        redir_valid = 1'b1; redir_src = JUMP; redir_taken = 1'b0;
        push_step(JUMP, 1'b0);
        cyc();
        redir_valid = 1'b0;
        check("step_redir_no_extra_step", {31'b0, pc_step}, 32'd0);
        fetch_ack(1, 32'h9999_AAAA, 1'b0);
        cyc();

        // Flush via PC_SRC_NEXT in HOLD.
        fetch_ack(0, 32'h0BAD_F00D, 1'b1);
        redir_valid = 1'b1; redir_src = NEXT;
        push_step(NEXT, 1'b0);
        cyc();
        redir_valid = 1'b0;
        check("flush_drop", {31'b0, inst_valid}, 32'd0);
        cyc();

        // Timeout after MAX_WAIT cycles without ack.
        repeat (MAX_WAIT - 1) cyc();
        check("timeout_before", {31'b0, timeout}, 32'd0);
        check("timeout_req_before", {31'b0, imem_req}, 32'd1);
        cyc();
        check("timeout_set", {31'b0, timeout}, 32'd1);
        check("timeout_req_held", {31'b0, imem_req}, 32'd1);
        fetch_ack(3, 32'hCAFE_0001, 1'b1);
        check("late_ack_hold", {31'b0, inst_valid}, 32'd1);
        check("timeout_sticky_hold", {31'b0, timeout}, 32'd1);
        consume();
        cyc();
        check("timeout_sticky_fetch", {31'b0, timeout}, 32'd1);

        // Reset in HOLD.
        fetch_ack(0, 32'h1234_5678, 1'b1);
        rst = 1'b1;
        cyc();
        check_reset_vals("rst_hold");
        rst = 1'b0;
        cyc();
        check("req_after_rst_hold", {31'b0, imem_req}, 32'd1);

        // Reset in FETCH with a simultaneous ack.
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
        cyc();
        check_reset_vals("rst_fetch");
        rst = 1'b0; imem_ack = 1'b0;
        cyc();
        check("req_after_rst_fetch", {31'b0, imem_req}, 32'd1);
        check("ack_ignored_valid", {31'b0, inst_valid}, 32'd0);
        cyc();
        check("ack_ignored_valid2", {31'b0, inst_valid}, 32'd0);
        check("ack_ignored_step", {31'b0, pc_step}, 32'd0);

        cyc();
        check("step_queue_drained", step_exp_q.size(), 32'd0);
        check("inst_queue_drained", inst_exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
